attribute_palette_decoder: RTL
==============================

// Module: attribute_palette_decoder
// PURPOSE
//   Text-mode attribute decoder for the VGA pipeline: maps an 8-bit character
//   attribute (fg = attr[3:0], bg = attr[7:4]) to fg/bg RGB colours.
//   - Colours come from a 16-entry CPU-writable palette.
//   - Two-stage registered pipeline with a valid strobe.
//   - Frame-counted blink, or 16-colour backgrounds, selectable at run time.
//   - Sits between the character/attribute fetch and the pixel serialiser.
// PARAMETERS
//   RGB_W         12  colour width. Must be a multiple of 3, range 3..24; C = RGB_W/3 bits per channel
//   BLINK_FRAMES  16  frame_i pulses per blink half-period (>=1)
// PORTS
//   clk_i          in   1      pixel-domain clock
//   rst_i          in   1      reset, asynchronous, active-high
//   en_i           in   1      attr_i valid this cycle
//   attr_i         in   8      character attribute byte
//   frame_i        in   1      one-cycle pulse per frame (start of vblank)
//   blink_en_i     in   1      1: attr[7] = blink, bg from attr[6:4]; 0: bg from attr[7:4]
//   pal_we_i       in   1      palette write strobe
//   pal_addr_i     in   4      palette entry to write
//   pal_data_i     in   RGB_W  palette write data {R,G,B}
//   fg_rgb_o       out  RGB_W  foreground colour {R,G,B}
//   bg_rgb_o       out  RGB_W  background colour {R,G,B}
//   valid_o        out  1      fg/bg outputs updated this cycle
//   blink_phase_o  out  1      current blink phase (1 = blinked text hidden)
// BEHAVIOUR
//   Reset (async, any time): all pipeline registers cleared.
//     - fg_rgb_o = 0, bg_rgb_o = 0, valid_o = 0, blink_phase_o = 0, blink counter = 0.
//     - Palette reloaded with CGA defaults. Each channel is a 4-bit level {0,5,A,F}
//       (16 entries, hex RGB): 000 00A 0A0 0AA A00 A0A A50 AAA
//       555 55F 5F5 5FF F55 F5F FF5 FFF.
//       C>4: left-aligned, low bits filled by repeating the nibble. C<4: upper C bits.
//   Pipeline, fixed latency 2.
//     - Stage 1 registers en_i, attr_i, blink_en_i.
//     - Stage 2 performs the palette lookup and registers fg/bg plus valid_o.
//     - Attr sampled at edge N appears at edge N+1 with valid_o = 1.
//     - Stage 2 with no valid input: valid_o = 0 and fg/bg hold their last value.
//       No bubbles are inserted.
//   Index rules, applied at stage 2 using the stage-1 copies:
//     - fg_idx = attr[3:0].
//     - blink_en = 0: bg_idx = attr[7:4]; blink ignored.
//     - blink_en = 1: bg_idx = {0, attr[6:4]}.
//       If attr[7] = 1 and blink_phase = 1, then fg colour = bg colour.
//   Blink counter:
//     - On frame_i, counter increments.
//     - At BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
//     - Counter and phase update on the same edge as frame_i. The stage-2 lookup uses
//       the registered phase value present before that edge.
//   Palette write:
//     - pal_we_i writes pal_data_i to entry pal_addr_i at the clock edge.
//     - A stage-2 lookup on the same edge reads the OLD value; the new value is
//       visible from the next edge. No bypass.
//   Simultaneous writes, frame pulses and lookups are all legal. Nothing stalls.
// TESTING (RGB_W = 12, BLINK_FRAMES = 16)
//   1. Reset mid-stream (rst_i pulse between clock edges)
//      -> outputs 0 immediately, valid_o 0, palette entry 1 back to 00A.
//   2. en_i = 1, attr 0x17, blink_en 0 -> two edges later:
//      valid_o = 1, fg 0xAAA, bg 0x00A. en_i = 0 -> valid_o 0, outputs hold.
//   3. blink_en 1, attr 0x9E, phase 0 -> fg 0xFF5, bg 0x00A.
//      After 16 frame_i pulses: blink_phase_o = 1, fg = bg = 0x00A.
//      After 16 more: phase 0.
//   4. blink_en 0, attr 0x9E -> fg 0xFF5, bg 0x55F (entry 9), at either blink phase.
//   5. Write entry 1 = 0x123, then attr 0x17 -> bg 0x123.
//      A write on the same edge as that lookup -> lookup returns 00A, next lookup 0x123.
//   6. Back-to-back en_i for 8 cycles with changing attr
//      -> 8 consecutive valid_o pulses, each output matching its input with latency 2.

Source files
------------

// File: rtl/attribute_palette_decoder_if.sv
// Attribute stream, palette write port and colour outputs of the attribute palette decoder.
interface attribute_palette_decoder_if #(
  parameter int RGB_W = 12
) ();
  logic             en_i;
  logic [7:0]       attr_i;
  logic             frame_i;
  logic             blink_en_i;
  logic             pal_we_i;
  logic [3:0]       pal_addr_i;
  logic [RGB_W-1:0] pal_data_i;
  logic [RGB_W-1:0] fg_rgb_o;
  logic [RGB_W-1:0] bg_rgb_o;
  logic             valid_o;
  logic             blink_phase_o;

  modport master (
    output en_i, attr_i, frame_i, blink_en_i, pal_we_i, pal_addr_i, pal_data_i,
    input  fg_rgb_o, bg_rgb_o, valid_o, blink_phase_o
  );

  modport slave (
    input  en_i, attr_i, frame_i, blink_en_i, pal_we_i, pal_addr_i, pal_data_i,
    output fg_rgb_o, bg_rgb_o, valid_o, blink_phase_o
  );
endinterface

// File: rtl/attribute_palette_decoder.sv
// Text-mode attribute decoder: 8-bit attribute -> fg/bg colours from a 16-entry
// writable palette, two-stage pipeline, frame-counted blink.
module attribute_palette_decoder #(
  parameter int RGB_W        = 12,
  parameter int BLINK_FRAMES = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  attribute_palette_decoder_if.slave bus
);
  localparam int C     = RGB_W / 3;
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  typedef logic [RGB_W-1:0] rgb_t;

  // A 4-bit level becomes a C-bit channel: left-aligned, nibble repeated into low bits.
  function automatic logic [C-1:0] expand_level(input logic [3:0] lvl);
    logic [C-1:0] ch;
    ch = '0;
    for (int b = 0; b < C; b++) ch[C-1-b] = lvl[3 - (b % 4)];
    return ch;
  endfunction

  function automatic rgb_t cga_default(input logic [3:0] idx);
    logic [11:0] hex;
    hex = 12'h000;
    case (idx)
      4'h0: hex = 12'h000;  4'h1: hex = 12'h00A;  4'h2: hex = 12'h0A0;  4'h3: hex = 12'h0AA;
      4'h4: hex = 12'hA00;  4'h5: hex = 12'hA0A;  4'h6: hex = 12'hA50;  4'h7: hex = 12'hAAA;
      4'h8: hex = 12'h555;  4'h9: hex = 12'h55F;  4'hA: hex = 12'h5F5;  4'hB: hex = 12'h5FF;
      4'hC: hex = 12'hF55;  4'hD: hex = 12'hF5F;  4'hE: hex = 12'hFF5;  4'hF: hex = 12'hFFF;
      default: hex = 12'h000;
    endcase
    return {expand_level(hex[11:8]), expand_level(hex[7:4]), expand_level(hex[3:0])};
  endfunction

  rgb_t             pal_q [16];
  logic             vld_p1_q;
  logic [7:0]       attr_p1_q;
  logic             blink_en_p1_q;
  logic             vld_p2_q;
  rgb_t             fg_p2_q, fg_p2_d;
  rgb_t             bg_p2_q, bg_p2_d;
  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             phase_q, phase_d;
  logic [3:0]       fg_idx, bg_idx;
  rgb_t             fg_lookup, bg_lookup;

  always_comb begin
    fg_idx    = attr_p1_q[3:0];
    bg_idx    = blink_en_p1_q ? {1'b0, attr_p1_q[6:4]} : attr_p1_q[7:4];
    fg_lookup = pal_q[fg_idx];
    bg_lookup = pal_q[bg_idx];
    fg_p2_d   = fg_p2_q;
    bg_p2_d   = bg_p2_q;
    if (vld_p1_q) begin
      bg_p2_d = bg_lookup;
      fg_p2_d = (blink_en_p1_q && attr_p1_q[7] && phase_q) ? bg_lookup : fg_lookup;
    end

    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (bus.frame_i) begin
      if (blink_cnt_q == CNT_LAST) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Stage 1: capture attribute; stage 2: registered lookup result.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p1_q      <= 1'b0;
      attr_p1_q     <= '0;
      blink_en_p1_q <= 1'b0;
      vld_p2_q      <= 1'b0;
      fg_p2_q       <= '0;
      bg_p2_q       <= '0;
      blink_cnt_q   <= '0;
      phase_q       <= 1'b0;
    end else begin
      vld_p1_q      <= bus.en_i;
      attr_p1_q     <= bus.attr_i;
      blink_en_p1_q <= bus.blink_en_i;
      vld_p2_q      <= vld_p1_q;
      fg_p2_q       <= fg_p2_d;
      bg_p2_q       <= bg_p2_d;
      blink_cnt_q   <= blink_cnt_d;
      phase_q       <= phase_d;
    end
  end

  // Write lands at the edge; a lookup on that same edge still sees the old entry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 16; i++) pal_q[i] <= cga_default(4'(i));
    end else if (bus.pal_we_i) begin
      pal_q[bus.pal_addr_i] <= bus.pal_data_i;
    end
  end

  assign bus.fg_rgb_o      = fg_p2_q;
  assign bus.bg_rgb_o      = bg_p2_q;
  assign bus.valid_o       = vld_p2_q;
  assign bus.blink_phase_o = phase_q;
endmodule
